// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, Status/Cause field positions,
// ExcCode values and the MTC0 write masks.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int ST_BEV    = 22;

    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    function automatic logic [31:0] merge_wmask(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// MTC0/MFC0 access port between the writeback stage and the CP0 register file.
interface cp0_regfile_if;
    logic        mtc0_en;
    logic [4:0]  mtc0_addr;
    logic [2:0]  mtc0_sel;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [2:0]  mfc0_sel;
    logic [31:0] mfc0_data;

    modport master (
        output mtc0_en, mtc0_addr, mtc0_sel, mtc0_data, mfc0_addr, mfc0_sel,
        input  mfc0_data
    );

    modport slave (
        input  mtc0_en, mtc0_addr, mtc0_sel, mtc0_data, mfc0_addr, mfc0_sel,
        output mfc0_data
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescale divider, free-running Count, Compare and the
// sticky timer interrupt TI.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             tick;
    logic [31:0]      count_inc;

    assign tick      = (div_q == DIV_LAST);
    assign count_inc = count_q + 32'd1;

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (wr_count) begin
            // a Count write restarts the prescaler so the value holds a full period
            div_d   = '0;
            count_d = wdata;
        end else if (tick) begin
            count_d = count_inc;
        end
        if (wr_compare) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end else if (!wr_count && tick && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: commits exception-detect updates, serves MTC0/MFC0 and
// feeds Status/Cause/EPC back to the pipeline.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [31:0]          exc_we,
    input  logic [31:0]          exc_epc,
    input  logic [31:0]          exc_badvaddr,
    input  logic [4:0]           exc_code,
    input  logic                 exc_bd,
    input  logic                 exc_exl,
    input  logic                 eret,
    cp0_regfile_if.slave         cpu,
    input  logic [5:0]           hw_int,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic [31:0]          epc,
    output logic                 timer_int
);
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [31:0] count, compare;
    logic        ti;
    logic        wr_ok;
    logic        wr_status, wr_cause, wr_epc, wr_count, wr_compare;
    logic        unused_exc_we;

    assign unused_exc_we = ^{exc_we[31:15], exc_we[11:9], exc_we[7:0]};

    assign wr_ok      = cpu.mtc0_en && (cpu.mtc0_sel == 3'd0);
    assign wr_status  = wr_ok && (cpu.mtc0_addr == CP0_STATUS);
    assign wr_cause   = wr_ok && (cpu.mtc0_addr == CP0_CAUSE);
    assign wr_epc     = wr_ok && (cpu.mtc0_addr == CP0_EPC);
    assign wr_count   = wr_ok && (cpu.mtc0_addr == CP0_COUNT);
    assign wr_compare = wr_ok && (cpu.mtc0_addr == CP0_COMPARE);

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wdata      (cpu.mtc0_data),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        // external lines are level-sampled; TI shares IP7 with hw_int[5]
        ip_hw_d    = {hw_int[5] | ti, hw_int[4:0]};

        if (exc_we[CP0_STATUS])  status_d[ST_EXL] = exc_exl;
        else if (eret)           status_d[ST_EXL] = 1'b0;
        else if (wr_status)      status_d = merge_wmask(STATUS_RST, cpu.mtc0_data, STATUS_WMASK);

        if (exc_we[CP0_CAUSE]) begin
            bd_d       = exc_bd;
            exc_code_d = exc_code;
        end else if (wr_cause) begin
            ip_sw_d = cpu.mtc0_data[CA_IP_LO+1:CA_IP_LO];
        end

        if (exc_we[CP0_EPC])     epc_d = exc_epc;
        else if (wr_epc)         epc_d = cpu.mtc0_data;

        if (exc_we[CP0_BADVADDR]) badvaddr_d = exc_badvaddr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RST;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
        end
    end

    assign status    = status_q;
    assign cause     = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b0};
    assign epc       = epc_q;
    assign timer_int = ti;

    always_comb begin
        cpu.mfc0_data = '0;
        if (cpu.mfc0_sel == 3'd0) begin
            case (cpu.mfc0_addr)
                CP0_BADVADDR: cpu.mfc0_data = badvaddr_q;
                CP0_COUNT:    cpu.mfc0_data = count;
                CP0_COMPARE:  cpu.mfc0_data = compare;
                CP0_STATUS:   cpu.mfc0_data = status;
                CP0_CAUSE:    cpu.mfc0_data = cause;
                CP0_EPC:      cpu.mfc0_data = epc_q;
                default:      cpu.mfc0_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, masked MTC0, exception commit,
// ERET, Count/Compare timer and hardware interrupt sampling.
module tb_cp0_regfile;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] exc_we, exc_epc, exc_badvaddr;
    logic [4:0]  exc_code;
    logic        exc_bd, exc_exl, eret;
    logic [5:0]  hw_int;
    logic [31:0] status, cause, epc;
    logic        timer_int;
    logic [31:0] rdata;
    int          checks = 0;
    int          errors = 0;

    cp0_regfile_if cpu_if ();

    cp0_regfile #(.COUNT_DIV(2), .STATUS_RST(32'h0040_0000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .exc_we       (exc_we),
        .exc_epc      (exc_epc),
        .exc_badvaddr (exc_badvaddr),
        .exc_code     (exc_code),
        .exc_bd       (exc_bd),
        .exc_exl      (exc_exl),
        .eret         (eret),
        .cpu          (cpu_if),
        .hw_int       (hw_int),
        .status       (status),
        .cause        (cause),
        .epc          (epc),
        .timer_int    (timer_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [2:0] sel, output logic [31:0] d);
        cpu_if.mfc0_addr = addr;
        cpu_if.mfc0_sel  = sel;
        #1;
        d = cpu_if.mfc0_data;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [2:0] sel, input logic [31:0] d);
        cpu_if.mtc0_en   = 1'b1;
        cpu_if.mtc0_addr = addr;
        cpu_if.mtc0_sel  = sel;
        cpu_if.mtc0_data = d;
        cyc();
        cpu_if.mtc0_en   = 1'b0;
    endtask

    initial begin
        resetn           = 1'b0;
        exc_we           = '0;
        exc_epc          = '0;
        exc_badvaddr     = '0;
        exc_code         = '0;
        exc_bd           = 1'b0;
        exc_exl          = 1'b0;
        eret             = 1'b0;
        hw_int           = '0;
        cpu_if.mtc0_en   = 1'b0;
        cpu_if.mtc0_addr = '0;
        cpu_if.mtc0_sel  = '0;
        cpu_if.mtc0_data = '0;
        cpu_if.mfc0_addr = '0;
        cpu_if.mfc0_sel  = '0;

        // release between edges; all reset reads complete before the first edge
        #7 resetn = 1'b1;
        chk("rst_status", status, 32'h0040_0000);
        chk("rst_cause", cause, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_ti", {31'b0, timer_int}, 32'h0);
        rd(5'd8, 3'd0, rdata);  chk("rst_badvaddr", rdata, 32'h0);
        rd(5'd9, 3'd0, rdata);  chk("rst_count", rdata, 32'h0);
        rd(5'd11, 3'd0, rdata); chk("rst_compare", rdata, 32'h0);
        rd(5'd14, 3'd0, rdata); chk("rst_mfc0_epc", rdata, 32'h0);
        rd(5'd12, 3'd0, rdata); chk("rst_mfc0_status", rdata, 32'h0040_0000);
        rd(5'd12, 3'd1, rdata); chk("rd_sel1_zero", rdata, 32'h0);
        rd(5'd5, 3'd0, rdata);  chk("rd_unimpl_zero", rdata, 32'h0);
        cyc();

        mtc0(CP0_STATUS, 3'd0, 32'hFFFF_FFFF);
        chk("mtc0_status_mask", status, 32'h0040_FF03);
        rd(5'd12, 3'd0, rdata); chk("mfc0_status", rdata, 32'h0040_FF03);
        mtc0(CP0_CAUSE, 3'd0, 32'hFFFF_FFFF);
        chk("mtc0_cause_mask", cause, 32'h0000_0300);
        mtc0(CP0_EPC, 3'd1, 32'h0000_DEAD);
        chk("mtc0_sel1_ignored", epc, 32'h0);
        mtc0(CP0_BADVADDR, 3'd0, 32'h0000_0055);
        rd(5'd8, 3'd0, rdata); chk("badvaddr_readonly", rdata, 32'h0);
        mtc0(CP0_STATUS, 3'd0, 32'h0);
        chk("status_clear", status, 32'h0040_0000);
        mtc0(CP0_CAUSE, 3'd0, 32'h0);
        chk("cause_clear", cause, 32'h0);

        // exception commit beats a same-cycle MTC0 to EPC
        exc_we           = 32'h0000_7100;
        exc_epc          = 32'hBFC0_0100;
        exc_badvaddr     = 32'h8000_0003;
        exc_code         = EXC_ADEL;
        exc_bd           = 1'b1;
        exc_exl          = 1'b1;
        cpu_if.mtc0_en   = 1'b1;
        cpu_if.mtc0_addr = CP0_EPC;
        cpu_if.mtc0_sel  = 3'd0;
        cpu_if.mtc0_data = 32'h0000_1234;
        cyc();
        exc_we         = '0;
        exc_exl        = 1'b0;
        exc_bd         = 1'b0;
        exc_code       = '0;
        cpu_if.mtc0_en = 1'b0;
        chk("exc_epc", epc, 32'hBFC0_0100);
        rd(5'd8, 3'd0, rdata); chk("exc_badvaddr", rdata, 32'h8000_0003);
        chk("exc_cause", cause, 32'h8000_0010);
        chk("exc_status_exl", status, 32'h0040_0002);

        eret = 1'b1;
        cyc();
        eret = 1'b0;
        chk("eret_clears_exl", status, 32'h0040_0000);
        eret    = 1'b1;
        exc_we  = 32'h0000_1000;
        exc_exl = 1'b1;
        cyc();
        eret    = 1'b0;
        exc_we  = '0;
        exc_exl = 1'b0;
        chk("exc_beats_eret", status, 32'h0040_0002);

        mtc0(CP0_COMPARE, 3'd0, 32'h0);
        mtc0(CP0_COUNT, 3'd0, 32'hFFFF_FFFE);
        rd(5'd9, 3'd0, rdata); chk("count_loaded", rdata, 32'hFFFF_FFFE);
        cyc();
        rd(5'd9, 3'd0, rdata); chk("count_hold", rdata, 32'hFFFF_FFFE);
        cyc();
        rd(5'd9, 3'd0, rdata); chk("count_ffffffff", rdata, 32'hFFFF_FFFF);
        chk("ti_before_match", {31'b0, timer_int}, 32'h0);
        cyc();
        cyc();
        rd(5'd9, 3'd0, rdata); chk("count_wrap", rdata, 32'h0);
        chk("ti_set", {31'b0, timer_int}, 32'h1);
        chk("cause_ti", {31'b0, cause[CA_TI]}, 32'h1);
        cyc();
        chk("cause_ip7_ti", {31'b0, cause[15]}, 32'h1);
        mtc0(CP0_COMPARE, 3'd0, 32'h5);
        chk("ti_cleared", {31'b0, timer_int}, 32'h0);
        chk("cause_ti_cleared", {31'b0, cause[CA_TI]}, 32'h0);
        cyc();
        chk("cause_ip7_cleared", {31'b0, cause[15]}, 32'h0);

        hw_int = 6'b000001;
        #1 chk("hwint_not_yet", {31'b0, cause[10]}, 32'h0);
        cyc();
        chk("hwint_sampled", {31'b0, cause[10]}, 32'h1);
        hw_int = 6'b000000;
        #1 chk("hwint_fall_held", {31'b0, cause[10]}, 32'h1);
        cyc();
        chk("hwint_fall", {31'b0, cause[10]}, 32'h0);
        hw_int = 6'b100000;
        cyc();
        hw_int = 6'b000000;
        chk("hwint5_ip7", cause, 32'h0000_8000 | 32'h8000_0010);

        cyc();
        cyc();
        cyc();
        #1 resetn = 1'b0;
        rd(5'd9, 3'd0, rdata); chk("async_rst_count", rdata, 32'h0);
        chk("async_rst_status", status, 32'h0040_0000);
        chk("async_rst_epc", epc, 32'h0);
        chk("async_rst_cause", cause, 32'h0);
        #1 resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
